uart_tx_feeder: RTL and testbench

Host-side request initiator for the UART transmitter. It buffers bytes written by the host in a small synchronous FIFO and drives them one at a time into the UART Tx request port (`UART_Tx_RQST` / `Tx_DATA` / `UART_Tx_READY_BUSY`), following that port's handshake. It sits between the host/APB write path and the UART Tx, in the Tx clock domain, and removes per-byte polling of `UART_Tx_READY_BUSY` from the host.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_sync_fifo.sv | 61 ++++++
 rtl/uart_tx_feeder.sv | 134 +++++++++++++
 tb/tb_uart_tx_feeder.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path: feeder FSM states,
// READY/BUSY polarity of the Tx request port and the data word width.
`ifndef WORD_LENGTH
`define WORD_LENGTH 8
`endif

package uart_pkg;

    // Word width normally comes from globals.vh; 8 bits when it is not defined.
    localparam int WORD_LENGTH = `WORD_LENGTH;

    localparam logic TX_READY = 1'b1;
    localparam logic TX_BUSY  = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } feeder_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Small synchronous FIFO with a show-ahead head (dout is always the oldest entry).
// Pushes while full and pops while empty are ignored.
module uart_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push is refused while full even if a pop frees a slot on the same edge.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers host bytes and hands them one at a time to the UART Tx request port,
// dropping a byte whose request is not accepted within REQ_TIMEOUT cycles.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int REQ_TIMEOUT = 1023
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WORD_LENGTH-1:0]     wr_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       UART_Tx_RQST,
    output logic [WORD_LENGTH-1:0]     Tx_DATA,
    input  logic                       UART_Tx_READY_BUSY,
    output logic                       tx_timeout
);

    localparam int TW = $clog2(REQ_TIMEOUT+1);

    feeder_state_t          state;
    feeder_state_t          state_next;
    logic [TW-1:0]          timer;
    logic [TW-1:0]          timer_next;
    logic                   rqst_next;
    logic [WORD_LENGTH-1:0] data_next;
    logic                   timeout_next;
    logic                   pop;
    logic                   ready;
    logic                   req_expired;
    logic [WORD_LENGTH-1:0] head;

    assign ready = UART_Tx_READY_BUSY;
    // The current REQ edge is the REQ_TIMEOUT-th one without acceptance.
    assign req_expired = (timer == TW'(REQ_TIMEOUT - 1));

    uart_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_LENGTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_en),
        .pop   (pop),
        .din   (wr_data),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            timer        <= '0;
            UART_Tx_RQST <= 1'b0;
            Tx_DATA      <= '0;
            tx_timeout   <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            state        <= state_next;
            timer        <= timer_next;
            UART_Tx_RQST <= rqst_next;
            Tx_DATA      <= data_next;
            tx_timeout   <= timeout_next;
            overflow     <= wr_en && full;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!empty && ready == TX_READY) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (ready == TX_BUSY) begin
                    state_next = WAIT;
                end else if (req_expired) begin
                    state_next = IDLE;
                end
            end
            WAIT: begin
                if (ready == TX_READY) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Next values of the registered outputs; Tx_DATA holds its last byte by default.
    always_comb begin
        rqst_next    = UART_Tx_RQST;
        data_next    = Tx_DATA;
        timer_next   = timer;
        timeout_next = 1'b0;
        pop          = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && ready == TX_READY) begin
                    data_next  = head;
                    rqst_next  = 1'b1;
                    timer_next = '0;
                end
            end
            REQ: begin
                if (ready == TX_BUSY) begin
                    pop       = 1'b1;
                    rqst_next = 1'b0;
                end else if (req_expired) begin
                    pop          = 1'b1;
                    rqst_next    = 1'b0;
                    timeout_next = 1'b1;
                end else begin
                    timer_next = timer + TW'(1);
                end
            end
            WAIT: begin
                rqst_next = 1'b0;
            end
            default: begin
                rqst_next = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: a queue-based model of the feeder checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_uart_tx_feeder;

    import uart_pkg::*;

    localparam int DEPTH       = 8;
    localparam int REQ_TIMEOUT = 4;
    localparam int CW          = $clog2(DEPTH+1);

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   wr_en;
    logic [WORD_LENGTH-1:0] wr_data;
    logic                   full;
    logic                   empty;
    logic [CW-1:0]          count;
    logic                   overflow;
    logic                   UART_Tx_RQST;
    logic [WORD_LENGTH-1:0] Tx_DATA;
    logic                   ready;
    logic                   tx_timeout;

    int checks = 0;
    int errors = 0;

    // Reference model state: queued bytes plus the request handshake phase.
    logic [WORD_LENGTH-1:0] mq[$];
    bit                     m_rqst     = 1'b0;
    bit                     m_after    = 1'b0;
    bit                     m_overflow = 1'b0;
    bit                     m_timeout  = 1'b0;
    logic [WORD_LENGTH-1:0] m_data     = '0;
    int                     m_age      = 0;

    uart_tx_feeder #(
        .DEPTH       (DEPTH),
        .REQ_TIMEOUT (REQ_TIMEOUT)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .wr_en              (wr_en),
        .wr_data            (wr_data),
        .full               (full),
        .empty              (empty),
        .count              (count),
        .overflow           (overflow),
        .UART_Tx_RQST       (UART_Tx_RQST),
        .Tx_DATA            (Tx_DATA),
        .UART_Tx_READY_BUSY (ready),
        .tx_timeout         (tx_timeout)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit w, input logic [WORD_LENGTH-1:0] d, input bit r);
        @(negedge clk);
        wr_en   = w;
        wr_data = d;
        ready   = r;
    endtask

    // Tx side: wait for a request, accept it by pulling ready low for one cycle.
    task automatic serveOne(output logic [WORD_LENGTH-1:0] got, input bit w, input logic [WORD_LENGTH-1:0] d);
        int waited;
        waited = 0;
        got    = '0;
        forever begin
            @(negedge clk);
            if (UART_Tx_RQST) break;
            wr_en = 1'b0;
            ready = 1'b1;
            waited++;
            if (waited > 40) begin
                checks++;
                errors++;
                $display("[TB] FAIL serve_wait actual=no_request required=request t=%0t", $time);
                return;
            end
        end
        got     = Tx_DATA;
        ready   = 1'b0;
        wr_en   = w;
        wr_data = d;
        @(negedge clk);
        checkOutput("accept_drop", 32'(UART_Tx_RQST), 0);
        ready = 1'b1;
        wr_en = 1'b0;
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            mq.delete();
            m_rqst     = 1'b0;
            m_after    = 1'b0;
            m_overflow = 1'b0;
            m_timeout  = 1'b0;
            m_data     = '0;
            m_age      = 0;
        end else begin : model_step
            bit was_full;
            bit do_pop;
            was_full   = (mq.size() == DEPTH);
            do_pop     = 1'b0;
            m_timeout  = 1'b0;
            m_overflow = wr_en && was_full;
            if (m_rqst) begin
                if (!ready) begin
                    do_pop  = 1'b1;
                    m_rqst  = 1'b0;
                    m_after = 1'b1;
                end else begin
                    m_age++;
                    if (m_age == REQ_TIMEOUT) begin
                        do_pop    = 1'b1;
                        m_rqst    = 1'b0;
                        m_timeout = 1'b1;
                    end
                end
            end else if (m_after) begin
                if (ready) m_after = 1'b0;
            end else if (mq.size() != 0 && ready) begin
                m_rqst = 1'b1;
                m_data = mq[0];
                m_age  = 0;
            end
            if (do_pop) void'(mq.pop_front());
            if (wr_en && !was_full) mq.push_back(wr_data);
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        checkOutput("m_rqst",     32'(UART_Tx_RQST), 32'(m_rqst));
        checkOutput("m_txdata",   32'(Tx_DATA),      32'(m_data));
        checkOutput("m_count",    32'(count),        32'(mq.size()));
        checkOutput("m_full",     32'(full),         32'(mq.size() == DEPTH));
        checkOutput("m_empty",    32'(empty),        32'(mq.size() == 0));
        checkOutput("m_overflow", 32'(overflow),     32'(m_overflow));
        checkOutput("m_timeout",  32'(tx_timeout),   32'(m_timeout));
    end

    initial begin
        logic [WORD_LENGTH-1:0] got;
        logic [WORD_LENGTH-1:0] tail [4];
        int hi;

        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_data = '0;
        ready   = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset_rqst",     32'(UART_Tx_RQST), 0);
        checkOutput("reset_empty",    32'(empty),        1);
        checkOutput("reset_count",    32'(count),        0);
        checkOutput("reset_full",     32'(full),         0);
        checkOutput("reset_overflow", 32'(overflow),     0);
        checkOutput("reset_timeout",  32'(tx_timeout),   0);
        checkOutput("reset_txdata",   32'(Tx_DATA),      0);
        rst = 1'b0;

        // Single byte: request one edge after the write, accepted two cycles later.
        applyStimulus(1, 8'hA5, 1);
        applyStimulus(0, 8'h00, 1);
        checkOutput("single_count1",  32'(count),        1);
        checkOutput("single_norqst",  32'(UART_Tx_RQST), 0);
        applyStimulus(0, 8'h00, 1);
        checkOutput("single_rqst",    32'(UART_Tx_RQST), 1);
        checkOutput("single_data",    32'(Tx_DATA),      32'h A5);
        applyStimulus(0, 8'h00, 0);
        checkOutput("single_hold",    32'(UART_Tx_RQST), 1);
        applyStimulus(0, 8'h00, 1);
        checkOutput("single_drop",    32'(UART_Tx_RQST), 0);
        checkOutput("single_count0",  32'(count),        0);
        checkOutput("single_retain",  32'(Tx_DATA),      32'h A5);

        // Burst of eight with ready low, then an overflowing ninth write.
        for (int i = 1; i <= 8; i++) applyStimulus(1, 8'(i), 0);
        applyStimulus(1, 8'h09, 0);
        checkOutput("burst_full",     32'(full),         1);
        checkOutput("burst_count",    32'(count),        8);
        applyStimulus(0, 8'h00, 0);
        checkOutput("burst_overflow", 32'(overflow),     1);
        checkOutput("burst_count_ov", 32'(count),        8);
        applyStimulus(0, 8'h00, 0);
        checkOutput("burst_ov_pulse", 32'(overflow),     0);
        for (int i = 1; i <= 8; i++) begin
            serveOne(got, 1'b0, 8'h00);
            checkOutput("burst_order", 32'(got), i);
        end

        // Ready held low in IDLE: nothing is requested until it returns.
        applyStimulus(1, 8'h11, 0);
        applyStimulus(1, 8'h22, 0);
        applyStimulus(1, 8'h33, 0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 8'h00, 0);
            checkOutput("lowready_norqst", 32'(UART_Tx_RQST), 0);
        end
        checkOutput("lowready_count", 32'(count), 3);
        serveOne(got, 1'b0, 8'h00);
        checkOutput("lowready_b0", 32'(got), 32'h11);
        serveOne(got, 1'b0, 8'h00);
        checkOutput("lowready_b1", 32'(got), 32'h22);
        serveOne(got, 1'b0, 8'h00);
        checkOutput("lowready_b2", 32'(got), 32'h33);

        // Timeout: 3C is never acknowledged and gets dropped, 3D follows.
        applyStimulus(1, 8'h3C, 1);
        applyStimulus(1, 8'h3D, 1);
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(0, 8'h00, 1);
            if (UART_Tx_RQST && Tx_DATA == 8'h3C) hi++;
            else if (hi > 0) break;
        end
        checkOutput("timeout_req_cycles", 32'(hi),         4);
        checkOutput("timeout_pulse",      32'(tx_timeout), 1);
        checkOutput("timeout_count",      32'(count),      1);
        applyStimulus(0, 8'h00, 1);
        checkOutput("timeout_pulse_end",  32'(tx_timeout),   0);
        checkOutput("timeout_next_rqst",  32'(UART_Tx_RQST), 1);
        checkOutput("timeout_next_data",  32'(Tx_DATA),      32'h3D);
        serveOne(got, 1'b0, 8'h00);
        checkOutput("timeout_next_sent",  32'(got),          32'h3D);

        // Simultaneous write and acceptance while full, then while half full.
        for (int i = 0; i < 8; i++) applyStimulus(1, 8'(8'h40 + i), 0);
        applyStimulus(0, 8'h00, 1);
        applyStimulus(1, 8'hEE, 0);
        checkOutput("simul_full",     32'(full),         1);
        checkOutput("simul_rqst",     32'(UART_Tx_RQST), 1);
        applyStimulus(0, 8'h00, 1);
        checkOutput("simul_overflow", 32'(overflow),     1);
        checkOutput("simul_count7",   32'(count),        7);
        checkOutput("simul_rqst_off", 32'(UART_Tx_RQST), 0);
        for (int i = 1; i <= 3; i++) begin
            serveOne(got, 1'b0, 8'h00);
            checkOutput("simul_drain", 32'(got), 32'h40 + i);
        end
        checkOutput("simul_count4", 32'(count), 4);
        serveOne(got, 1'b1, 8'h55);
        checkOutput("simul_halfdata",  32'(got),   32'h44);
        checkOutput("simul_count_eq",  32'(count), 4);
        tail[0] = 8'h45;
        tail[1] = 8'h46;
        tail[2] = 8'h47;
        tail[3] = 8'h55;
        for (int i = 0; i < 4; i++) begin
            serveOne(got, 1'b0, 8'h00);
            checkOutput("simul_tail", 32'(got), 32'(tail[i]));
        end

        // Reset in the middle of a request.
        applyStimulus(1, 8'h77, 1);
        applyStimulus(0, 8'h00, 1);
        applyStimulus(0, 8'h00, 1);
        checkOutput("rstmid_rqst", 32'(UART_Tx_RQST), 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("rstmid_async_rqst", 32'(UART_Tx_RQST), 0);
        checkOutput("rstmid_empty",      32'(empty),        1);
        checkOutput("rstmid_count",      32'(count),        0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 8'h00, 1);
            checkOutput("rstmid_quiet", 32'(UART_Tx_RQST), 0);
        end
        applyStimulus(1, 8'h78, 1);
        applyStimulus(0, 8'h00, 1);
        applyStimulus(0, 8'h00, 1);
        checkOutput("rstmid_new_rqst", 32'(UART_Tx_RQST), 1);
        checkOutput("rstmid_new_data", 32'(Tx_DATA),      32'h78);
        serveOne(got, 1'b0, 8'h00);

        // Randomized traffic, checked cycle by cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            bit low_phase;
            low_phase = ((i / 100) % 4) == 3;
            applyStimulus(($urandom % 3) == 0, WORD_LENGTH'($urandom),
                          low_phase ? (($urandom % 8) == 0) : (($urandom % 4) != 0));
        end
        repeat (5) applyStimulus(0, 8'h00, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
